uart_echo_checker: RTL and testbench

- Initiator side of the UART echo loopback. The far end echoes every received byte.
- Drives the tx side of a UART_Pong instance with a pseudo-random byte sequence and waits for each echoed byte on the rx side.
- Compares each echo against the sent byte and reports error count, timeout and pass/fail.
- Used as the on-board link self-test ahead of the RSA data path.

---
 rtl/uart_echo_checker.sv | 159 +++++++++++++++
 tb/tb_uart_echo_checker.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_checker.sv
// ---------------------------------------------------------------------------
// uart_echo_checker
//
// Link self-test initiator for the UART echo loopback. Sends NUM_BYTES bytes
// from an 8-bit Galois LFSR to the transmitter, one at a time, and waits for
// the far end to echo each byte back. Counts mismatched echoes and
// unexpected bytes, aborts the run on an echo timeout, and reports
// pass/fail when the run ends.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   start         one-cycle pulse; begins a run when busy=0
//   tx_start      one-cycle pulse to the transmitter
//   tx_data       byte being sent; held until the next send
//   tx_busy       transmitter busy
//   rx_readable   a received byte is waiting
//   rx_data       the received byte
//   rx_used_tick  one-cycle pulse releasing the received byte
//   busy          run in progress
//   done          one-cycle pulse at run end (normal or timeout)
//   pass          1 iff the last run ended with no errors and no timeout
//   err_count     mismatches plus unexpected bytes, saturating at 16'hFFFF
//   timeout_flag  last run aborted on an echo timeout
// ---------------------------------------------------------------------------
module uart_echo_checker #(
  parameter int unsigned NUM_BYTES      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SEED           = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_readable,
  input  logic [7:0]  rx_data,
  output logic        rx_used_tick,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic        timeout_flag
);

  // Wide enough to hold TIMEOUT_CYCLES-1, the last count value before abort.
  localparam int unsigned   TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  // Comparing against the last index keeps the byte counter at 16 bits.
  localparam logic [15:0]   NB_LAST  = 16'(NUM_BYTES - 1);
  // An all-zero Galois LFSR never leaves zero.
  localparam logic [7:0]    SEED_NZ  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0]    TAPS     = 8'hB8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ECHO, FINISH} state_t;

  state_t        state_reg;
  logic [7:0]    lfsr_reg;
  logic [7:0]    lfsr_next;
  logic [15:0]   byte_cnt_reg;
  logic [TW-1:0] to_cnt_reg;
  logic [15:0]   err_next;
  logic          rx_ok;

  // Right-shift Galois step: the bit leaving at position 0 is fed back into
  // the tap positions.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lfsr
      if (gi == 7) begin : g_top
        assign lfsr_next[gi] = lfsr_reg[0] & TAPS[gi];
      end else begin : g_low
        assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (lfsr_reg[0] & TAPS[gi]);
      end
    end
  endgenerate

  // The cycle after a release the receiver may still show the byte it has
  // just been told to drop; ignore it so it is not consumed twice.
  assign rx_ok    = rx_readable & ~rx_used_tick;
  assign err_next = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      lfsr_reg     <= SEED_NZ;
      byte_cnt_reg <= '0;
      to_cnt_reg   <= '0;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      rx_used_tick <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= 16'h0000;
      timeout_flag <= 1'b0;
    end else begin
      tx_start     <= 1'b0;
      rx_used_tick <= 1'b0;
      done         <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Stray bytes between runs are drained silently.
          if (rx_ok) begin
            rx_used_tick <= 1'b1;
          end
          if (start) begin
            err_count    <= 16'h0000;
            timeout_flag <= 1'b0;
            pass         <= 1'b0;
            lfsr_reg     <= SEED_NZ;
            byte_cnt_reg <= '0;
            busy         <= 1'b1;
            state_reg    <= SEND;
          end
        end
        SEND: begin
          // Nothing should arrive before the byte is sent; draining it
          // comes first and the send is retried next cycle.
          if (rx_ok) begin
            rx_used_tick <= 1'b1;
            err_count    <= err_next;
          end else if (!tx_busy) begin
            tx_start   <= 1'b1;
            tx_data    <= lfsr_reg;
            to_cnt_reg <= '0;
            state_reg  <= WAIT_ECHO;
          end
        end
        WAIT_ECHO: begin
          // A byte arriving on the timeout cycle still counts as the echo.
          if (rx_ok) begin
            rx_used_tick <= 1'b1;
            if (rx_data != tx_data) begin
              err_count <= err_next;
            end
            lfsr_reg     <= lfsr_next;
            byte_cnt_reg <= byte_cnt_reg + 16'd1;
            state_reg    <= (byte_cnt_reg == NB_LAST) ? FINISH : SEND;
          end else if (to_cnt_reg == TO_LAST) begin
            timeout_flag <= 1'b1;
            state_reg    <= FINISH;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        FINISH: begin
          done      <= 1'b1;
          pass      <= (err_count == 16'h0000) && !timeout_flag;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_checker.sv
module tb_uart_echo_checker;

  localparam int         NB     = 4;
  localparam int         TO     = 100;
  localparam logic [7:0] SEED_T = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_readable;
  logic [7:0]  rx_data;
  logic        rx_used_tick;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic        timeout_flag;

  uart_echo_checker #(
    .NUM_BYTES(NB),
    .TIMEOUT_CYCLES(TO),
    .SEED(SEED_T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .rx_readable(rx_readable),
    .rx_data(rx_data),
    .rx_used_tick(rx_used_tick),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---- cycle counter and monitor -----------------------------------------
  int         cyc = 0;
  int         n_tx = 0;
  int         n_tick = 0;
  int         n_done = 0;
  int         to_rise_cyc = -1;
  logic       to_prev = 1'b0;
  logic [7:0] tx_log [1024];
  int         tx_cyc [1024];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      tx_log[n_tx % 1024] = tx_data;
      tx_cyc[n_tx % 1024] = cyc;
      n_tx++;
    end
    if (rx_used_tick) n_tick++;
    if (done) n_done++;
    if (timeout_flag && !to_prev) to_rise_cyc = cyc;
    to_prev = timeout_flag;
  end

  // ---- far-end echo model --------------------------------------------------
  // Echoes each sent byte echo_delay cycles later, XOR'd with masks[k] for
  // byte k of the run. Like a real receiver, it keeps the byte visible for
  // one extra cycle after the release pulse. inj_cnt requests unsolicited
  // bytes.
  logic       echo_en = 1'b1;
  int         echo_delay = 20;
  logic [7:0] masks [4];
  int         inj_cnt = 0;

  initial begin
    int         inj_done;
    int         echo_idx;
    int         pend_cnt;
    int         hold_cnt;
    logic       pending;
    logic       tick_seen;
    logic [7:0] pend_data;
    logic [7:0] m;
    inj_done = 0; echo_idx = 0; pend_cnt = 0; hold_cnt = 0;
    pending = 1'b0; tick_seen = 1'b0; pend_data = 8'h00;
    rx_readable = 1'b0;
    rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!busy) begin
        pending  = 1'b0;
        echo_idx = 0;
      end
      if (rx_readable) begin
        hold_cnt++;
        if (tick_seen || hold_cnt > 20) begin
          rx_readable = 1'b0;
          tick_seen   = 1'b0;
          hold_cnt    = 0;
        end else if (rx_used_tick) begin
          tick_seen = 1'b1;
        end
      end
      if (busy && tx_start && echo_en) begin
        m = 8'h00;
        if (echo_idx < 4) m = masks[echo_idx];
        pending   = 1'b1;
        pend_cnt  = echo_delay;
        pend_data = tx_data ^ m;
        echo_idx++;
      end else if (pending && !rx_readable) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          rx_readable = 1'b1;
          rx_data     = pend_data;
          pending     = 1'b0;
        end
      end
      if (inj_cnt != inj_done && !rx_readable && !pending) begin
        rx_readable = 1'b1;
        rx_data     = 8'($urandom);
        inj_done++;
      end
    end
  end

  // ---- reference model -----------------------------------------------------
  function automatic logic [7:0] model_byte(input int k);
    logic [7:0] s;
    s = SEED_T;
    for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    return s;
  endfunction

  // ---- stimulus helpers ------------------------------------------------------
  int start_cyc;

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // ---- tests -----------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, tx_data, rx_used_tick, busy, done, pass, err_count, timeout_flag} !== 30'd0) begin
      errors++;
      $display("FAIL reset_during: outputs=%h required 0",
               {tx_start, tx_data, rx_used_tick, busy, done, pass, err_count, timeout_flag});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, tx_data, rx_used_tick, busy, done, pass, err_count, timeout_flag} !== 30'd0) begin
      errors++;
      $display("FAIL reset_after: outputs=%h required 0",
               {tx_start, tx_data, rx_used_tick, busy, done, pass, err_count, timeout_flag});
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_loopback();
    bit got;
    int t0, k0, d0;
    logic [7:0] exp_fixed [4];
    exp_fixed[0] = 8'h01; exp_fixed[1] = 8'hB8; exp_fixed[2] = 8'h5C; exp_fixed[3] = 8'h2E;
    echo_en = 1'b1; echo_delay = 20;
    for (int i = 0; i < 4; i++) masks[i] = 8'h00;
    t0 = n_tx; k0 = n_tick; d0 = n_done;
    pulse_start();
    wait_done(1000, got);
    checks++;
    if (!got) begin errors++; $display("FAIL loop_done: no done pulse within bound"); end
    checks++;
    if (tx_cyc[t0 % 1024] !== start_cyc + 2) begin
      errors++;
      $display("FAIL loop_latency: first tx_start cycle %0d required %0d", tx_cyc[t0 % 1024], start_cyc + 2);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_log[(t0 + i) % 1024] !== exp_fixed[i]) begin
        errors++;
        $display("FAIL loop_byte%0d: tx_data %h required %h", i, tx_log[(t0 + i) % 1024], exp_fixed[i]);
      end
    end
    checks++;
    if ((n_tx - t0) != 4 || (n_tick - k0) != 4 || (n_done - d0) != 1) begin
      errors++;
      $display("FAIL loop_counts: tx=%0d ticks=%0d done=%0d required 4 4 1", n_tx - t0, n_tick - k0, n_done - d0);
    end
    checks++;
    if ({pass, timeout_flag, busy} !== 3'b100 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL loop_result: pass=%b to=%b busy=%b err=%0d required 1 0 0 0", pass, timeout_flag, busy, err_count);
    end
    $display("loopback: err_count=%0d pass=%b timeout=%b", err_count, pass, timeout_flag);
  endtask

  task automatic test_unsolicited();
    bit got;
    int k0;
    k0 = n_tick;
    @(negedge clk);
    inj_cnt++;
    repeat (8) @(negedge clk);
    checks++;
    if ((n_tick - k0) != 1 || err_count !== 16'd0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL unsol_idle: ticks=%0d err=%0d pass=%b required 1 0 1", n_tick - k0, err_count, pass);
    end
    tx_busy = 1'b1;
    pulse_start();
    repeat (5) @(negedge clk);
    inj_cnt++;
    repeat (8) @(negedge clk);
    checks++;
    if (err_count !== 16'd1) begin
      errors++;
      $display("FAIL unsol_send: err_count %0d required 1", err_count);
    end
    tx_busy = 1'b0;
    wait_done(1000, got);
    checks++;
    if (!got || err_count !== 16'd1 || pass !== 1'b0 || timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL unsol_result: done=%b err=%0d pass=%b to=%b required 1 1 0 0", got, err_count, pass, timeout_flag);
    end
    $display("unsolicited: err_count=%0d pass=%b", err_count, pass);
  endtask

  task automatic test_mismatch();
    bit got;
    int t0;
    echo_delay = 20;
    masks[0] = 8'h00; masks[1] = 8'h01; masks[2] = 8'h00; masks[3] = 8'h01;
    t0 = n_tx;
    pulse_start();
    wait_done(1000, got);
    checks++;
    if (!got || err_count !== 16'd2 || pass !== 1'b0 || (n_tx - t0) != 4) begin
      errors++;
      $display("FAIL mismatch: done=%b err=%0d pass=%b tx=%0d required 1 2 0 4", got, err_count, pass, n_tx - t0);
    end
    $display("mismatch: err_count=%0d pass=%b", err_count, pass);
  endtask

  task automatic test_timeout();
    bit got;
    int t0, d0;
    echo_en = 1'b0;
    t0 = n_tx; d0 = n_done;
    pulse_start();
    wait_done(400, got);
    checks++;
    if (!got || timeout_flag !== 1'b1 || pass !== 1'b0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL timeout_result: done=%b to=%b pass=%b err=%0d required 1 1 0 0", got, timeout_flag, pass, err_count);
    end
    checks++;
    if ((n_tx - t0) != 1 || (n_done - d0) != 1) begin
      errors++;
      $display("FAIL timeout_counts: tx=%0d done=%0d required 1 1", n_tx - t0, n_done - d0);
    end
    checks++;
    if (to_rise_cyc - tx_cyc[t0 % 1024] != TO) begin
      errors++;
      $display("FAIL timeout_delay: %0d cycles required %0d", to_rise_cyc - tx_cyc[t0 % 1024], TO);
    end
    echo_en = 1'b1;
    $display("timeout: timeout_flag=%b pass=%b", timeout_flag, pass);
  endtask

  task automatic test_busy_hold();
    bit got;
    int t0, b;
    for (int i = 0; i < 4; i++) masks[i] = 8'h00;
    tx_busy = 1'b1;
    t0 = n_tx;
    pulse_start();
    repeat (150) @(negedge clk);
    checks++;
    if ((n_tx - t0) != 0 || timeout_flag !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_hold: tx=%0d to=%b busy=%b required 0 0 1", n_tx - t0, timeout_flag, busy);
    end
    tx_busy = 1'b0;
    b = cyc;
    wait_done(1000, got);
    checks++;
    if (tx_cyc[t0 % 1024] !== b + 1) begin
      errors++;
      $display("FAIL busy_release: tx_start cycle %0d required %0d", tx_cyc[t0 % 1024], b + 1);
    end
    checks++;
    if (!got || pass !== 1'b1 || timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL busy_result: done=%b pass=%b to=%b required 1 1 0", got, pass, timeout_flag);
    end
    $display("busy_hold: pass=%b timeout=%b", pass, timeout_flag);
  endtask

  task automatic test_reset_midrun();
    bit got;
    int t0, d0;
    echo_delay = 30;
    t0 = n_tx;
    pulse_start();
    for (int i = 0; i < 20 && n_tx == t0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_start, tx_data, rx_used_tick, busy, done, pass, err_count, timeout_flag} !== 30'd0) begin
      errors++;
      $display("FAIL midrst_outputs: outputs=%h required 0",
               {tx_start, tx_data, rx_used_tick, busy, done, pass, err_count, timeout_flag});
    end
    d0 = n_done;
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (n_done != d0) begin
      errors++;
      $display("FAIL midrst_nodone: done pulses %0d required 0", n_done - d0);
    end
    t0 = n_tx;
    echo_delay = 20;
    pulse_start();
    wait_done(1000, got);
    checks++;
    if (!got || tx_log[t0 % 1024] !== model_byte(0) || pass !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rerun: done=%b first=%h pass=%b required 1 %h 1", got, tx_log[t0 % 1024], pass, model_byte(0));
    end
    $display("reset_midrun: rerun pass=%b", pass);
  endtask

  task automatic test_random();
    bit got;
    int t0, exp_err, bad;
    for (int r = 0; r < 6; r++) begin
      echo_delay = $urandom_range(1, 60);
      exp_err = 0;
      for (int i = 0; i < 4; i++) begin
        masks[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        if (masks[i] != 8'h00) exp_err++;
      end
      t0 = n_tx;
      pulse_start();
      wait_done(1000, got);
      bad = 0;
      for (int i = 0; i < NB; i++)
        if (tx_log[(t0 + i) % 1024] !== model_byte(i)) bad++;
      checks++;
      if (!got || err_count !== 16'(exp_err) || pass !== (exp_err == 0) || timeout_flag !== 1'b0
          || (n_tx - t0) != NB || bad != 0) begin
        errors++;
        $display("FAIL random_run%0d: done=%b err=%0d pass=%b to=%b tx=%0d badbytes=%0d required 1 %0d %b 0 %0d 0",
                 r, got, err_count, pass, timeout_flag, n_tx - t0, bad, exp_err, exp_err == 0, NB);
      end
      $display("random run %0d: delay=%0d err_count=%0d pass=%b", r, echo_delay, err_count, pass);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) masks[i] = 8'h00;
    test_reset();
    test_loopback();
    test_unsolicited();
    test_mismatch();
    test_timeout();
    test_busy_hold();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
